rom_load_ctrl: RTL and testbench
================================

# rom_load_ctrl

Sequences the HPS file-download byte stream into the Hack instruction ROM's write port and owns the CPU reset during a load. It pairs big-endian bytes into 16-bit words, flushes a trailing odd byte, optionally zero-fills the unused ROM tail, and releases the CPU a fixed number of cycles after the image is complete. It sits between `hps_io` (ioctl_* outputs) and the `dpram` ROM write port. Its `cpu_reset` output is ORed with the user and OSD reset sources.

## Interface
- `ADDR_W`, 15, ROM word-address width. ROM depth is 2^ADDR_W words.
- `CLEAR_TAIL`, 1, when 1, zero-fill ROM words above the last loaded word after each download.
- `HOLD_CYCLES`, 16, number of cycles `cpu_reset` stays high after the image is complete. Range 1..65535.

Ports:
- `clk_sys` in 1: system clock. All logic is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 25: byte address of `ioctl_dout`.
- `ioctl_dout` in 8: download byte.
- `rom_wraddress` out ADDR_W: ROM write address.
- `rom_data` out 16: ROM write data.
- `rom_wren` out 1: ROM write enable, one cycle per word.
- `cpu_reset` out 1: active-high CPU hold.
- `load_done` out 1: one-cycle pulse when the CPU is released.
- `word_count` out ADDR_W+1: number of words in the last image (highest written index + 1).
- `overflow` out 1: sticky; a byte addressed beyond ROM depth arrived during the current or last download.

## Operation
- States:
  - IDLE: post-reset, no image.
  - LOAD: download in progress.
  - FLUSH: write the trailing odd byte.
  - CLEAR: zero-fill the ROM tail.
  - HOLD: count off the release delay.
  - RUN: CPU executing.
- `cpu_reset` = 1 in every state except RUN.
- IDLE/RUN → LOAD on `ioctl_download`=1.
  - On entry: clear `word_count`, `overflow`, the high-byte-valid flag and the hold counter.
- LOAD byte handling uses `ioctl_addr[0]`, not a toggle.
  - `ioctl_wr` with addr[0]=0: latch the byte as the high byte; set hi_valid.
  - `ioctl_wr` with addr[0]=1: write {hi, byte} to word `ioctl_addr[ADDR_W:1]`; clear hi_valid.
  - A low byte with hi_valid=0 uses hi=8'h00.
  - After each write, `word_count` = max(word_count, index+1).
- `ioctl_addr[24:ADDR_W+1]` nonzero: the byte is dropped (no write) and `overflow` is set.
- LOAD exit, on `ioctl_download` falling:
  - hi_valid=1 → FLUSH.
  - Otherwise → CLEAR if CLEAR_TAIL=1, else HOLD.
- FLUSH: one cycle. Writes {hi, 8'h00} to the pending word index and updates `word_count`. Then → CLEAR or HOLD.
- CLEAR:
  - Writes 16'h0000 at address `word_count`, `word_count`+1, …, 2^ADDR_W−1, one word per cycle.
  - Goes to HOLD after the last address is written.
  - If `word_count` = 2^ADDR_W, passes straight through to HOLD with no writes.
  - `word_count` is not modified.
- HOLD: counts HOLD_CYCLES cycles, then → RUN. `load_done` pulses in the first RUN cycle.
- `ioctl_download` rising in FLUSH, CLEAR or HOLD: abort immediately to LOAD.
  - The partially completed flush or clear is abandoned.
  - `cpu_reset` stays 1 throughout.
- An empty download (download falls with no bytes) → CLEAR zero-fills the whole ROM (word_count=0).

## Timing
- Reset values:
  - state=IDLE
  - `cpu_reset`=1
  - `rom_wren`=0
  - `rom_wraddress`=0
  - `rom_data`=0
  - `load_done`=0
  - `word_count`=0
  - `overflow`=0
- All outputs are registered.
- A low-byte strobe at cycle N gives `rom_wren`=1 with address/data valid at N+1. Writes are back-to-back capable.
- Download falling at cycle N: FLUSH write (if any) at N+1.
- CLEAR writes occupy consecutive cycles; no idle gaps.
- HOLD lasts exactly HOLD_CYCLES cycles. `cpu_reset` falls on the same edge that `load_done` rises.
- `reset_n` low mid-operation immediately forces all reset values. Any in-flight `rom_wren` is dropped.
- `ioctl_wr` while not in LOAD is ignored.

## Test plan
- Load 4 bytes (A2 00 FF 11) with ADDR_W=4, CLEAR_TAIL=1, HOLD_CYCLES=16:
  - Writes word0=0xA200 and word1=0xFF11.
  - Then zeros at words 2..15 on 14 consecutive cycles.
  - `cpu_reset` falls 16 cycles after the last clear write.
  - `load_done` pulses once; `word_count`=2.
- Odd length, 3 bytes (12 34 56), CLEAR_TAIL=0:
  - FLUSH writes word1=0x5600 one cycle after download falls.
  - `word_count`=2; no clear writes.
- Overflow with ADDR_W=4: a byte at address 0x20 produces no write and `overflow`=1. It clears at the next download start.
- Abort: assert `ioctl_download` during CLEAR at word 7.
  - Clear stops and state is LOAD next cycle.
  - `cpu_reset` stays 1; no `load_done`.
- Reset: pull `reset_n` low during LOAD mid-pair. All outputs return to reset values asynchronously; no write is issued after release.
- Full image: 2^ADDR_W words loaded → CLEAR issues zero writes; HOLD follows directly.

Source files
------------

// File: rtl/rom_load_ctrl.sv
// Download sequencer: pairs big-endian ioctl bytes into 16-bit ROM words,
// optionally zero-fills the ROM tail, and holds the CPU in reset until the image is settled.
module rom_load_ctrl #(
    parameter int ADDR_W      = 15,
    parameter bit CLEAR_TAIL  = 1'b1,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] rom_wraddress,
    output logic [15:0]       rom_data,
    output logic              rom_wren,
    output logic              cpu_reset,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_CLEAR,
        S_HOLD,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [15:0]     HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t              state_q;
    logic [7:0]          hi_q;
    logic                hi_valid_q;
    logic [ADDR_W-1:0]   pend_q;
    logic [ADDR_W:0]     clr_q;
    logic [15:0]         hold_q;

    logic                addr_oob;
    logic [ADDR_W-1:0]   byte_idx;
    logic [ADDR_W:0]     idx_p1;
    logic [ADDR_W:0]     pend_p1;
    logic [ADDR_W:0]     flush_wc;

    assign addr_oob = |ioctl_addr[24:ADDR_W+1];
    assign byte_idx = ioctl_addr[ADDR_W:1];
    assign idx_p1   = {1'b0, byte_idx} + (ADDR_W+1)'(1);
    assign pend_p1  = {1'b0, pend_q} + (ADDR_W+1)'(1);
    assign flush_wc = (pend_p1 > word_count) ? pend_p1 : word_count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            hi_q          <= '0;
            hi_valid_q    <= 1'b0;
            pend_q        <= '0;
            clr_q         <= '0;
            hold_q        <= '0;
            rom_wraddress <= '0;
            rom_data      <= '0;
            rom_wren      <= 1'b0;
            cpu_reset     <= 1'b1;
            load_done     <= 1'b0;
            word_count    <= '0;
            overflow      <= 1'b0;
        end else begin
            rom_wren  <= 1'b0;
            load_done <= 1'b0;
            if (state_q != S_HOLD) begin
                hold_q <= '0;
            end

            // A new download preempts every non-LOAD state, abandoning any flush/clear.
            if (state_q != S_LOAD && ioctl_download) begin
                state_q    <= S_LOAD;
                cpu_reset  <= 1'b1;
                word_count <= '0;
                overflow   <= 1'b0;
                hi_valid_q <= 1'b0;
                hold_q     <= '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (!ioctl_download) begin
                            if (hi_valid_q) begin
                                rom_wren      <= 1'b1;
                                rom_wraddress <= pend_q;
                                rom_data      <= {hi_q, 8'h00};
                                word_count    <= flush_wc;
                                clr_q         <= flush_wc;
                                hi_valid_q    <= 1'b0;
                                state_q       <= S_FLUSH;
                            end else begin
                                clr_q   <= word_count;
                                state_q <= (CLEAR_TAIL && word_count != DEPTH) ? S_CLEAR : S_HOLD;
                            end
                        end else if (ioctl_wr) begin
                            if (addr_oob) begin
                                overflow <= 1'b1;
                            end else if (!ioctl_addr[0]) begin
                                hi_q       <= ioctl_dout;
                                hi_valid_q <= 1'b1;
                                pend_q     <= byte_idx;
                            end else begin
                                rom_wren      <= 1'b1;
                                rom_wraddress <= byte_idx;
                                rom_data      <= {(hi_valid_q ? hi_q : 8'h00), ioctl_dout};
                                hi_valid_q    <= 1'b0;
                                if (idx_p1 > word_count) begin
                                    word_count <= idx_p1;
                                end
                            end
                        end
                    end
                    S_FLUSH: begin
                        state_q <= (CLEAR_TAIL && word_count != DEPTH) ? S_CLEAR : S_HOLD;
                    end
                    S_CLEAR: begin
                        if (clr_q == DEPTH) begin
                            state_q <= S_HOLD;
                        end else begin
                            rom_wren      <= 1'b1;
                            rom_wraddress <= clr_q[ADDR_W-1:0];
                            rom_data      <= '0;
                            clr_q         <= clr_q + (ADDR_W+1)'(1);
                            if (clr_q == DEPTH - (ADDR_W+1)'(1)) begin
                                state_q <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (hold_q == HOLD_LAST) begin
                            state_q   <= S_RUN;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: two instances (tail clear on/off) share stimulus;
// expected ROM writes are queued per instance and popped by a negedge monitor.
module tb_rom_load_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [3:0]  addr1, addr2;
    logic [15:0] data1, data2;
    logic        wren1, wren2, cpu1, cpu2, ld1, ld2, ov1, ov2;
    logic [4:0]  wc1, wc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc1 = 0;
    int ld_cnt1 = 0;
    int ld_cnt2 = 0;
    logic [19:0] q1[$];
    logic [19:0] q2[$];
    logic [19:0] e1, e2;

    rom_load_ctrl #(.ADDR_W(4), .CLEAR_TAIL(1'b1), .HOLD_CYCLES(16)) dut (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_wraddress(addr1), .rom_data(data1), .rom_wren(wren1),
        .cpu_reset(cpu1), .load_done(ld1), .word_count(wc1), .overflow(ov1)
    );

    rom_load_ctrl #(.ADDR_W(4), .CLEAR_TAIL(1'b0), .HOLD_CYCLES(16)) dut_nc (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .rom_wraddress(addr2), .rom_data(data2), .rom_wren(wren2),
        .cpu_reset(cpu2), .load_done(ld2), .word_count(wc2), .overflow(ov2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wren1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr_clr: got addr %0h data %0h, expected no write", addr1, data1);
            end else begin
                e1 = q1.pop_front();
                if ({addr1, data1} !== e1) begin
                    errors++;
                    $display("FAIL wr_clr: got addr %0h data %0h, expected addr %0h data %0h",
                             addr1, data1, e1[19:16], e1[15:0]);
                end
            end
            last_wr_cyc1 = cyc;
        end
        if (wren2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL wr_nc: got addr %0h data %0h, expected no write", addr2, data2);
            end else begin
                e2 = q2.pop_front();
                if ({addr2, data2} !== e2) begin
                    errors++;
                    $display("FAIL wr_nc: got addr %0h data %0h, expected addr %0h data %0h",
                             addr2, data2, e2[19:16], e2[15:0]);
                end
            end
        end
        if (ld1) ld_cnt1++;
        if (ld2) ld_cnt2++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] idx, input logic [7:0] hi, input logic [7:0] lo);
        q1.push_back({idx, hi, lo});
        q2.push_back({idx, hi, lo});
        send_byte({20'd0, idx, 1'b0}, hi);
        send_byte({20'd0, idx, 1'b1}, lo);
    endtask

    task automatic push_clears(input int from, input int upto);
        for (int i = from; i <= upto; i++) q1.push_back({4'(i), 16'h0000});
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while ((cpu1 || cpu2) && n < 100) begin
            tick();
            n++;
        end
        check(name, {31'd0, cpu1 | cpu2}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, n, t1, t2;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        tick();
        tick();
        check("rst_cpu_reset", {31'd0, cpu1}, 32'd1);
        check("rst_wren", {31'd0, wren1}, 32'd0);
        check("rst_addr", {28'd0, addr1}, 32'd0);
        check("rst_data", {16'd0, data1}, 32'd0);
        check("rst_load_done", {31'd0, ld1}, 32'd0);
        check("rst_word_count", {27'd0, wc1}, 32'd0);
        check("rst_overflow", {31'd0, ov1}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Even image with tail clear and hold timing
        ioctl_download = 1'b1;
        tick();
        send_word(4'd0, 8'hA2, 8'h00);
        send_word(4'd1, 8'hFF, 8'h11);
        push_clears(2, 15);
        ioctl_download = 1'b0;
        run = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wren1) run++;
            else if (run > 0) break;
        end
        check("clear_consecutive", run, 32'd14);
        n = 0;
        while (cpu1 && n < 40) begin
            tick();
            n++;
        end
        check("hold_cycles", cyc - last_wr_cyc1, 32'd16);
        check("load_done_at_release", {31'd0, ld1}, 32'd1);
        check("word_count_even", {27'd0, wc1}, 32'd2);
        wait_run("run_even");

        // Odd image: flush of trailing byte
        ioctl_download = 1'b1;
        tick();
        send_word(4'd0, 8'h12, 8'h34);
        send_byte(25'd2, 8'h56);
        q1.push_back({4'd1, 16'h5600});
        q2.push_back({4'd1, 16'h5600});
        push_clears(2, 15);
        ioctl_download = 1'b0;
        tick();
        check("flush_wren", {31'd0, wren2}, 32'd1);
        check("flush_addr", {28'd0, addr2}, 32'd1);
        check("flush_data", {16'd0, data2}, 32'h5600);
        wait_run("run_odd");
        check("word_count_odd_nc", {27'd0, wc2}, 32'd2);
        check("word_count_odd_clr", {27'd0, wc1}, 32'd2);

        // Overflow byte only: no write, sticky flag, whole-ROM clear
        ioctl_download = 1'b1;
        tick();
        send_byte(25'h20, 8'hEE);
        tick();
        check("ovf_set", {30'd0, ov1, ov2}, 32'd3);
        push_clears(0, 15);
        ioctl_download = 1'b0;
        wait_run("run_ovf");
        check("ovf_sticky", {30'd0, ov1, ov2}, 32'd3);
        check("word_count_empty", {27'd0, wc1}, 32'd0);

        // Abort during clear at word 7
        ioctl_download = 1'b1;
        tick();
        check("ovf_cleared", {30'd0, ov1, ov2}, 32'd0);
        send_word(4'd0, 8'h01, 8'h02);
        send_word(4'd1, 8'h03, 8'h04);
        push_clears(2, 7);
        ioctl_download = 1'b0;
        n = 0;
        while (!(wren1 && addr1 == 4'd7) && n < 30) begin
            tick();
            n++;
        end
        check("abort_reached_word7", {31'd0, (n < 30)}, 32'd1);
        ioctl_download = 1'b1;
        tick();
        check("abort_no_write", {31'd0, wren1}, 32'd0);
        check("abort_cpu_reset", {30'd0, cpu1, cpu2}, 32'd3);
        send_word(4'd0, 8'h77, 8'h88);
        tick();

        // Reset mid-pair, with a write in flight
        send_byte(25'd2, 8'h99);
        ioctl_addr = 25'd3;
        ioctl_dout = 8'h55;
        ioctl_wr = 1'b1;
        tick();
        #1 reset_n = 1'b0;
        #1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        check("mrst_wren", {30'd0, wren1, wren2}, 32'd0);
        check("mrst_cpu_reset", {30'd0, cpu1, cpu2}, 32'd3);
        check("mrst_addr", {28'd0, addr1}, 32'd0);
        check("mrst_data", {16'd0, data1}, 32'd0);
        check("mrst_word_count", {27'd0, wc1}, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        send_byte(25'd1, 8'h42);
        repeat (3) tick();
        check("idle_cpu_reset", {31'd0, cpu1}, 32'd1);

        // Full image: no clear writes, hold follows directly
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) send_word(4'(i), 8'(8'hC0 + i), 8'(8'h0F ^ i));
        ioctl_download = 1'b0;
        t1 = 0;
        t2 = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t1 == 0 && !cpu1) t1 = t;
            if (t2 == 0 && !cpu2) t2 = t;
        end
        check("full_release_clr", t1, 32'd17);
        check("full_release_nc", t2, 32'd17);
        check("full_word_count", {22'd0, wc1, wc2}, {22'd0, 5'd16, 5'd16});

        repeat (3) tick();
        check("q_clr_drained", q1.size(), 32'd0);
        check("q_nc_drained", q2.size(), 32'd0);
        check("load_done_count_clr", ld_cnt1, 32'd4);
        check("load_done_count_nc", ld_cnt2, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
